// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer averaging scheduler.
package accel_pkg;

  localparam int unsigned ACCEL_W          = 12;
  localparam int unsigned LOG2_AVG_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE,
    ACC_X,
    ACC_Y,
    ACC_Z,
    DONE
  } state_t;

  typedef struct packed {
    logic [ACCEL_W-1:0] x;
    logic [ACCEL_W-1:0] y;
    logic [ACCEL_W-1:0] z;
  } sample_t;

endpackage

// File: rtl/imu_ready_sync.sv
// Two-flop synchronizer for the IMU data-ready strobe plus rising-edge detector.
module imu_ready_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/accel_avg_scheduler.sv
// Per-axis window averager sharing one adder across X/Y/Z with a one-deep pending buffer.
// Define ACCEL_SIGNED_EN to treat samples as two's complement.
module accel_avg_scheduler
  import accel_pkg::*;
#(
  parameter int unsigned LOG2_AVG = LOG2_AVG_DEFAULT
) (
  input  logic               c50m,
  input  logic               reset,
  input  logic               imu_data_ready,
  input  logic [ACCEL_W-1:0] accel_x,
  input  logic [ACCEL_W-1:0] accel_y,
  input  logic [ACCEL_W-1:0] accel_z,
  input  logic               overrun_clr,
  output logic [ACCEL_W-1:0] out_x,
  output logic [ACCEL_W-1:0] out_y,
  output logic [ACCEL_W-1:0] out_z,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned AW = ACCEL_W + LOG2_AVG;

  state_t              state, state_nx;
  sample_t             raw, work, pend;
  logic                evt, pending, last;
  logic [LOG2_AVG-1:0] sample_cnt;
  logic [AW-1:0]       acc_x, acc_y, acc_z, add_a, add_sum;
  logic [ACCEL_W-1:0]  add_s;

  function automatic logic [AW-1:0] ext(input logic [ACCEL_W-1:0] s);
`ifdef ACCEL_SIGNED_EN
    return {{LOG2_AVG{s[ACCEL_W-1]}}, s};
`else
    return {{LOG2_AVG{1'b0}}, s};
`endif
  endfunction

  function automatic logic [ACCEL_W-1:0] avg(input logic [AW-1:0] a);
`ifdef ACCEL_SIGNED_EN
    return ACCEL_W'($signed(a) >>> LOG2_AVG);
`else
    return ACCEL_W'(a >> LOG2_AVG);
`endif
  endfunction

  imu_ready_sync u_sync (
    .clk     (c50m),
    .rst     (reset),
    .async_in(imu_data_ready),
    .pulse   (evt)
  );

  assign raw  = '{x: accel_x, y: accel_y, z: accel_z};
  assign busy = (state != IDLE);
  assign last = (sample_cnt == {LOG2_AVG{1'b1}});

  always_ff @(posedge c50m or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (evt || pending) state_nx = ACC_X;
      ACC_X:   state_nx = ACC_Y;
      ACC_Y:   state_nx = ACC_Z;
      ACC_Z:   state_nx = last ? DONE : IDLE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Single shared adder: the state picks which accumulator/axis pair it serves.
  always_comb begin
    add_a = '0;
    add_s = '0;
    case (state)
      ACC_X: begin add_a = acc_x; add_s = work.x; end
      ACC_Y: begin add_a = acc_y; add_s = work.y; end
      ACC_Z: begin add_a = acc_z; add_s = work.z; end
      default: ;
    endcase
    add_sum = add_a + ext(add_s);
  end

  always_ff @(posedge c50m or posedge reset) begin
    if (reset) begin
      work       <= '0;
      pend       <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      sample_cnt <= '0;
      acc_x      <= '0;
      acc_y      <= '0;
      acc_z      <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_z      <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      // Pending is drained before a new edge so samples stay in arrival order.
      if (state == IDLE) begin
        if (pending) begin
          work    <= pend;
          pending <= evt;
          if (evt) pend <= raw;
        end else if (evt) begin
          work <= raw;
        end
      end else if (evt && !pending) begin
        pend    <= raw;
        pending <= 1'b1;
      end

      if (evt && pending && busy) overrun <= 1'b1;
      else if (overrun_clr)       overrun <= 1'b0;

      case (state)
        ACC_X: acc_x <= add_sum;
        ACC_Y: acc_y <= add_sum;
        ACC_Z: begin
          acc_z <= add_sum;
          if (!last) sample_cnt <= sample_cnt + 1'b1;
        end
        DONE: begin
          out_x      <= avg(acc_x);
          out_y      <= avg(acc_y);
          out_z      <= avg(acc_z);
          out_valid  <= 1'b1;
          acc_x      <= '0;
          acc_y      <= '0;
          acc_z      <= '0;
          sample_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_avg_scheduler.sv
// Directed self-checking bench for accel_avg_scheduler at LOG2_AVG=3.
module tb_accel_avg_scheduler;

  logic        c50m;
  logic        reset;
  logic        imu_data_ready;
  logic [11:0] accel_x, accel_y, accel_z;
  logic        overrun_clr;
  logic [11:0] out_x, out_y, out_z;
  logic        out_valid, busy, overrun;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned vcnt  = 0;
  int unsigned v0;

  accel_avg_scheduler #(.LOG2_AVG(3)) dut (
    .c50m          (c50m),
    .reset         (reset),
    .imu_data_ready(imu_data_ready),
    .accel_x       (accel_x),
    .accel_y       (accel_y),
    .accel_z       (accel_z),
    .overrun_clr   (overrun_clr),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_z         (out_z),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial c50m = 1'b0;
  always #10 c50m = ~c50m;

  always @(negedge c50m) if (out_valid) vcnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One sample: strobe high 4 cycles, 20 cycles total; optional latency probes.
  task automatic send(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z,
                      input bit timed);
    accel_x = x;
    accel_y = y;
    accel_z = z;
    imu_data_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge c50m);
      if (k == 4) imu_data_ready = 1'b0;
      if (timed) begin
        if (k == 3) check("busy_hi", busy, 1);
        if (k >= 6 && k <= 8) check("latency", out_valid, (k == 7));
        if (k == 7) check("busy_lo", busy, 0);
      end
    end
  endtask

  // Four edges two cycles apart: 1st captured, 2nd pending, 3rd re-pended, 4th dropped.
  task automatic burst(input bit clr_on_drop);
    accel_x = 12'd0;
    accel_y = 12'd0;
    accel_z = 12'd0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check("ovr_no_drop", overrun, 0);
      imu_data_ready = (k % 2 == 0);
      @(negedge c50m);
    end
    overrun_clr = clr_on_drop;
    @(negedge c50m);
    overrun_clr = 1'b0;
    check("ovr_set", overrun, 1);
    repeat (20) @(negedge c50m);
    v0 = vcnt;
    for (int i = 0; i < 4; i++) send(12'd80, 12'd160, 12'd8, 1'b0);
    check("burst_novalid", vcnt - v0, 0);
    send(12'd80, 12'd160, 12'd8, 1'b0);
    check("burst_valid", vcnt - v0, 1);
    check("burst_x", out_x, 50);
    check("burst_y", out_y, 100);
    check("burst_z", out_z, 5);
    check("ovr_sticky", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge c50m);
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);
  endtask

  initial begin
    reset          = 1'b1;
    imu_data_ready = 1'b0;
    overrun_clr    = 1'b0;
    accel_x        = '0;
    accel_y        = '0;
    accel_z        = '0;
    repeat (3) @(negedge c50m);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_z", out_z, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    @(negedge c50m);

    // Constant window, latency probed on the 8th sample.
    v0 = vcnt;
    for (int i = 0; i < 7; i++) send(12'd100, 12'd200, 12'd300, 1'b0);
    check("const_novalid", vcnt - v0, 0);
    send(12'd100, 12'd200, 12'd300, 1'b1);
    check("const_valid", vcnt - v0, 1);
    check("const_x", out_x, 100);
    check("const_y", out_y, 200);
    check("const_z", out_z, 300);

    // Ramp: truncating average, full-scale Y.
    for (int i = 0; i < 8; i++) send(12'(i), 12'hFFF, 12'(8 * i), 1'b0);
    check("ramp_x", out_x, 3);
    check("ramp_y", out_y, 12'hFFF);
    check("ramp_z", out_z, 28);

    burst(1'b0);
    burst(1'b1);

    // Reset mid-window discards the partial sums.
    for (int i = 0; i < 5; i++) send(12'd7, 12'd7, 12'd7, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge c50m);
    check("mid_rst_x", out_x, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge c50m);
    v0 = vcnt;
    for (int i = 0; i < 7; i++) send(12'd50, 12'd50, 12'd50, 1'b0);
    check("post_rst_novalid", vcnt - v0, 0);
    send(12'd50, 12'd50, 12'd50, 1'b0);
    check("post_rst_valid", vcnt - v0, 1);
    check("post_rst_x", out_x, 50);

    // Signedness: 0xFFC averages to 0xFFC either way; alternating 0xFFC/0x004 does not.
    for (int i = 0; i < 8; i++) send(12'hFFC, 12'h800, 12'h000, 1'b0);
    check("neg_x", out_x, 12'hFFC);
    check("neg_y", out_y, 12'h800);
    for (int i = 0; i < 8; i++)
      send((i % 2 == 0) ? 12'hFFC : 12'h004, 12'h800, (i % 2 == 0) ? 12'h7FF : 12'h000, 1'b0);
`ifdef ACCEL_SIGNED_EN
    check("alt_x", out_x, 12'h000);
`else
    check("alt_x", out_x, 12'h800);
`endif
    check("alt_y", out_y, 12'h800);
    check("alt_z", out_z, 12'h3FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
